alu_logic_issue: RTL and testbench

- Sequential front end that drives the combinational ALU logic unit: accepts logic-op requests over a valid/ready handshake and decodes a MIPS-style funct into the 2-bit logic_fn.
- Holds operands in an issue register that feeds the logic unit, then captures its result into a small output FIFO with valid/ready backpressure.
- Sits between decode/dispatch and ALU writeback in the Stage3 ALU top.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_result_fifo.sv | 73 +++++++
 rtl/alu_logic_issue.sv | 127 ++++++++++++
 tb/tb_alu_logic_issue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic-op issue path.
//   - MIPS funct encodings accepted by the logic unit front end
//   - 2-bit logic_fn encodings driven to the combinational logic unit
//   - result_entry_t: one queued result (data, tag, illegal flag)
//   - funct_is_legal(): true for the four logic functs
package alu_pkg;

    localparam int DATA_W    = 32;
    // The entry type carries tags up to this width; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 16;

    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;

    localparam logic [1:0] LFN_AND = 2'b00;
    localparam logic [1:0] LFN_OR  = 2'b01;
    localparam logic [1:0] LFN_XOR = 2'b10;
    localparam logic [1:0] LFN_NOR = 2'b11;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [TAG_MAX_W-1:0] tag;
        logic                 illegal;
    } result_entry_t;

    function automatic logic funct_is_legal(input logic [5:0] funct);
        logic legal;
        legal = 1'b0;
        case (funct)
            FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR: legal = 1'b1;
            default:                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Small synchronous FIFO holding logic-unit results until writeback takes them.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push          write push_data at the tail (ignored when full unless popping)
//   push_data     entry to write
//   pop           advance the head (ignored when empty)
//   pop_data      head entry; holds the last popped entry while empty
//   count         occupancy, 0..DEPTH
//   full, empty   occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // While empty the slot under rd_ptr is stale, so present the last popped entry.
    assign pop_data = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/alu_logic_issue.sv
// Issue front end for the combinational ALU logic unit.
// Accepts logic-op requests (valid/ready), decodes the MIPS funct into logic_fn,
// holds the op in a single issue register (S1) that drives the logic unit, and
// queues {result, tag, illegal} into an output FIFO with valid/ready backpressure.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           request handshake
//   in_funct, in_x_data,
//   in_y_data, in_tag           request payload
//   logic_x_data, logic_y_data,
//   logic_fn                    to the logic unit, straight from S1
//   logic_result                combinational result from the logic unit
//   out_valid/out_ready         result handshake
//   out_data, out_tag,
//   out_illegal                 FIFO head
module alu_logic_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic [31:0]       in_x_data,
    input  logic [31:0]       in_y_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [31:0]       logic_x_data,
    output logic [31:0]       logic_y_data,
    output logic [1:0]        logic_fn,
    input  logic [31:0]       logic_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              s1_v;
    logic [31:0]       s1_x;
    logic [31:0]       s1_y;
    logic [1:0]        s1_fn;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_illegal;

    logic              accept;
    logic              pop;
    logic              push_ok;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count_unused;
    logic              tag_unused;
    result_entry_t     push_entry;
    result_entry_t     head_entry;

    // Legal functs 0x24..0x27 differ only in bits [1:0], which are the logic_fn code.
    function automatic logic [1:0] decode_fn(input logic [5:0] funct);
        return funct_is_legal(funct) ? funct[1:0] : LFN_AND;
    endfunction

    assign pop      = out_valid && out_ready;
    assign push_ok  = !fifo_full || pop;
    assign push     = s1_v && push_ok;
    assign in_ready = !s1_v || push_ok;
    assign accept   = in_valid && in_ready;

    // Stage S1: issue register feeding the logic unit
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_fn      <= LFN_AND;
            s1_tag     <= '0;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_v       <= 1'b1;
            s1_fn      <= decode_fn(in_funct);
            s1_tag     <= in_tag;
            s1_illegal <= !funct_is_legal(in_funct);
            // Illegal ops run AND on zero operands, so the queued result is 0.
            s1_x       <= funct_is_legal(in_funct) ? in_x_data : '0;
            s1_y       <= funct_is_legal(in_funct) ? in_y_data : '0;
        end else if (push) begin
            s1_v <= 1'b0;
        end
    end

    assign logic_x_data = s1_x;
    assign logic_y_data = s1_y;
    assign logic_fn     = s1_fn;

    always_comb begin
        push_entry         = '0;
        push_entry.data    = logic_result;
        push_entry.tag     = TAG_MAX_W'(s1_tag);
        push_entry.illegal = s1_illegal;
    end

    // Stage FIFO: results wait here for writeback
    alu_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(result_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (fifo_count_unused),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_data    = head_entry.data;
    assign out_tag     = head_entry.tag[TAG_W-1:0];
    assign out_illegal = head_entry.illegal;
    assign tag_unused  = ^head_entry.tag;

endmodule

// File: tb/tb_alu_logic_issue.sv
module tb_alu_logic_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [31:0] in_x_data;
    logic [31:0] in_y_data;
    logic [4:0]  in_tag;
    logic [31:0] logic_x_data;
    logic [31:0] logic_y_data;
    logic [1:0]  logic_fn;
    logic [31:0] logic_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_logic_issue #(.DEPTH(2), .TAG_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct     (in_funct),
        .in_x_data    (in_x_data),
        .in_y_data    (in_y_data),
        .in_tag       (in_tag),
        .logic_x_data (logic_x_data),
        .logic_y_data (logic_y_data),
        .logic_fn     (logic_fn),
        .logic_result (logic_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_illegal  (out_illegal)
    );

    // Combinational logic unit the issue block drives.
    always_comb begin
        logic_result = '0;
        case (logic_fn)
            2'b00: logic_result = logic_x_data & logic_y_data;
            2'b01: logic_result = logic_x_data | logic_y_data;
            2'b10: logic_result = logic_x_data ^ logic_y_data;
            2'b11: logic_result = ~(logic_x_data | logic_y_data);
            default: logic_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [5:0] f, input logic [31:0] x,
                            input logic [31:0] y, input logic [4:0] t);
        in_valid  = v;
        in_funct  = f;
        in_x_data = x;
        in_y_data = y;
        in_tag    = t;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_funct = '0; in_x_data = '0; in_y_data = '0; in_tag = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++; if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests_run++; if (out_tag !== 5'd0) begin tests_failed++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
        tests_run++; if (out_illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_out_illegal got %b want 0", out_illegal); end
        tests_run++; if (logic_fn !== 2'b00) begin tests_failed++; $display("FAIL reset_logic_fn got %b want 00", logic_fn); end
        tests_run++; if (logic_x_data !== 32'h0 || logic_y_data !== 32'h0) begin
            tests_failed++; $display("FAIL reset_logic_xy got %h/%h want 0/0", logic_x_data, logic_y_data); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive_op(1'b1, 6'h26, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL single_in_ready got %b want 1", in_ready); end
        tick();
        drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_valid got %b want 0", out_valid); end
        tests_run++; if (logic_fn !== 2'b10 || logic_x_data !== 32'hF0F0_F0F0 || logic_y_data !== 32'h0FF0_0FF0) begin
            tests_failed++; $display("FAIL single_issue got fn=%b x=%h y=%h want 10/f0f0f0f0/0ff00ff0", logic_fn, logic_x_data, logic_y_data); end
        tick();
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %b want 1", out_valid); end
        tests_run++; if (out_data !== 32'hFF00_FF00) begin tests_failed++; $display("FAIL single_data got %h want ff00ff00", out_data); end
        tests_run++; if (out_tag !== 5'd3 || out_illegal !== 1'b0) begin
            tests_failed++; $display("FAIL single_tag got tag=%0d ill=%b want 3/0", out_tag, out_illegal); end
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain got %b want 0", out_valid); end
        tests_run++; if (out_data !== 32'hFF00_FF00 || out_tag !== 5'd3) begin
            tests_failed++; $display("FAIL single_hold got %h/%0d want ff00ff00/3", out_data, out_tag); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fn  [3];
        logic [31:0] exp [3];
        fn[0] = 6'h24; fn[1] = 6'h25; fn[2] = 6'h27;
        exp[0] = 32'hAAAA_0000; exp[1] = 32'hFFFF_5555; exp[2] = 32'h0000_AAAA;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b1, fn[i], 32'hAAAA_5555, 32'hFFFF_0000, 5'(i + 1));
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            if (i >= 1) begin
                tests_run++; if (out_valid !== 1'b1 || out_data !== exp[i-1] || out_tag !== 5'(i)) begin
                    tests_failed++; $display("FAIL b2b_out[%0d] got v=%b %h tag=%0d want 1 %h tag=%0d", i - 1, out_valid, out_data, out_tag, exp[i-1], i); end
            end
        end
        drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_data !== exp[2] || out_tag !== 5'd3) begin
            tests_failed++; $display("FAIL b2b_out[2] got v=%b %h tag=%0d want 1 %h tag=3", out_valid, out_data, out_tag, exp[2]); end
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_full();
        logic [31:0] xs  [4];
        logic [31:0] exp [4];
        xs[0] = 32'h1111_1111; xs[1] = 32'h2222_2222; xs[2] = 32'h3333_3333; xs[3] = 32'h4444_4444;
        exp[0] = 32'h1E1E_1E1E; exp[1] = 32'h2D2D_2D2D; exp[2] = 32'h3C3C_3C3C; exp[3] = 32'h4B4B_4B4B;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(1'b1, 6'h26, xs[i], 32'h0F0F_0F0F, 5'(i + 4));
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_accept[%0d] got %b want 1", i, in_ready); end
            tick();
        end
        drive_op(1'b1, 6'h26, xs[3], 32'h0F0F_0F0F, 5'd7);
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_block got %b want 0", in_ready); end
        tick();
        tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd4) begin
            tests_failed++; $display("FAIL full_stall got rdy=%b v=%b tag=%0d want 0/1/4", in_ready, out_valid, out_tag); end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL full_release got %b want 1", in_ready); end
        tests_run++; if (out_data !== exp[0] || out_tag !== 5'd4) begin
            tests_failed++; $display("FAIL full_out[0] got %h tag=%0d want %h tag=4", out_data, out_tag, exp[0]); end
        tick();
        drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
        for (int i = 1; i < 4; i++) begin
            tests_run++; if (out_valid !== 1'b1 || out_data !== exp[i] || out_tag !== 5'(i + 4)) begin
                tests_failed++; $display("FAIL full_out[%0d] got v=%b %h tag=%0d want 1 %h tag=%0d", i, out_valid, out_data, out_tag, exp[i], i + 4); end
            tick();
        end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL full_drain got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive_op(1'b1, 6'h20, 32'hFFFF_FFFF, 32'h1234_5678, 5'd9);
        tick();
        tests_run++; if (logic_fn !== 2'b00 || logic_x_data !== 32'h0 || logic_y_data !== 32'h0) begin
            tests_failed++; $display("FAIL illegal_issue got fn=%b x=%h y=%h want 00/0/0", logic_fn, logic_x_data, logic_y_data); end
        drive_op(1'b1, 6'h24, 32'hFFFF_FFFF, 32'h1234_5678, 5'd10);
        tick();
        drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
        tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h0 || out_illegal !== 1'b1 || out_tag !== 5'd9) begin
            tests_failed++; $display("FAIL illegal_out got v=%b %h ill=%b tag=%0d want 1 0 1 9", out_valid, out_data, out_illegal, out_tag); end
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_illegal !== 1'b0 || out_tag !== 5'd10) begin
            tests_failed++; $display("FAIL illegal_next got v=%b %h ill=%b tag=%0d want 1 12345678 0 10", out_valid, out_data, out_illegal, out_tag); end
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL illegal_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_op(1'b1, 6'h25, 32'h0000_0001, 32'h0000_0002, 5'd11);
        tick();
        drive_op(1'b1, 6'h27, 32'h0000_0003, 32'h0000_0004, 5'd12);
        tick();
        drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
        tests_run++; if (out_valid !== 1'b1 || logic_fn !== 2'b11) begin
            tests_failed++; $display("FAIL rstmid_pre got v=%b fn=%b want 1/11", out_valid, logic_fn); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || logic_fn !== 2'b00 || out_data !== 32'h0) begin
            tests_failed++; $display("FAIL rstmid_post got v=%b rdy=%b fn=%b data=%h want 0/1/00/0", out_valid, in_ready, logic_fn, out_data); end
        out_ready = 1'b1;
        drive_op(1'b1, 6'h25, 32'h00FF_0000, 32'h0000_00FF, 5'd17);
        tick();
        drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h00FF_00FF || out_tag !== 5'd17) begin
            tests_failed++; $display("FAIL rstmid_next got v=%b %h tag=%0d want 1 00ff00ff 17", out_valid, out_data, out_tag); end
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_alone got %b want 0", out_valid); end
    endtask

    task automatic test_pointer_wrap();
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        int max_cnt = 0;
        logic [4:0] want_tag;
        while (recv < 10 && cyc < 80) begin
            out_ready = (cyc % 2 == 0);
            if (sent < 10) drive_op(1'b1, 6'h25, 32'h0, 32'(sent), 5'(sent + 20));
            else           drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
            if (out_valid && out_ready) begin
                want_tag = 5'(recv + 20);
                tests_run++; if (out_data !== 32'(recv) || out_tag !== want_tag) begin
                    tests_failed++; $display("FAIL wrap_out[%0d] got %h tag=%0d want %h tag=%0d", recv, out_data, out_tag, 32'(recv), want_tag); end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
        end
        tests_run++; if (recv != 10) begin tests_failed++; $display("FAIL wrap_count got %0d results want 10", recv); end
        tests_run++; if (max_cnt > 2) begin tests_failed++; $display("FAIL wrap_occupancy got %0d want <=2", max_cnt); end
        out_ready = 1'b1;
        drive_op(1'b0, 6'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_drain got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_illegal();
        test_reset_mid();
        test_pointer_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
